line_window_buf: RTL

LINE_WINDOW_BUF -- requirements
Module: line_window_buf

---
 rtl/line_window_buf.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/line_window_buf.sv
// line_window_buf: sliding KxK window generator for a raster pixel stream.
//
// Handshake: a pixel is accepted on every rising clk edge where valid_in=1;
// there is no ready, the block always takes one pixel per cycle. valid_out
// is a one-cycle pulse, registered on the edge that accepted the pixel
// completing the window; pixel_windows/win_row/win_col are meaningful only
// while valid_out=1 and hold their last value otherwise.
//
// Window element (r,c), r=0 oldest row, c=0 leftmost column, sits at slice
// i=r*K+c, bits [(K*K-1-i)*CH*DATA_W +: CH*DATA_W]; top-left is the MSB slice.
module line_window_buf #(
    parameter int DATA_W = 8,
    parameter int CH     = 1,
    parameter int WIDTH  = 13,
    parameter int HEIGHT = 13,
    parameter int K      = 3,
    parameter int STRIDE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sof,
    input  logic                          valid_in,
    input  logic [CH*DATA_W-1:0]          pixel_in,
    output logic [K*K*CH*DATA_W-1:0]      pixel_windows,
    output logic                          valid_out,
    output logic [$clog2(HEIGHT)-1:0]     win_row,
    output logic [$clog2(WIDTH)-1:0]      win_col,
    output logic                          frame_done
);

    localparam int PW       = CH * DATA_W;
    localparam int ROW_W    = $clog2(HEIGHT);
    localparam int COL_W    = $clog2(WIDTH);
    localparam int PH_W     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int OUT_ROWS = (HEIGHT - K) / STRIDE + 1;
    localparam int OUT_COLS = (WIDTH - K) / STRIDE + 1;

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_HIT = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_HIT = ROW_W'(K - 1);
    localparam logic [PH_W-1:0]  PH_LAST       = PH_W'(STRIDE - 1);
    localparam logic [COL_W-1:0] OCOL_LAST     = COL_W'(OUT_COLS - 1);
    localparam logic [ROW_W-1:0] OROW_LAST     = ROW_W'(OUT_ROWS - 1);

    // Position of the next pixel to be accepted. The phase counters count
    // pixels/rows since the last window-aligned position so the stride test
    // needs no divider; ocol/orow are the window indices at that position.
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [PH_W-1:0]  col_ph;
    logic [PH_W-1:0]  row_ph;
    logic [COL_W-1:0] ocol_cnt;
    logic [ROW_W-1:0] orow_cnt;

    // Position of the pixel on pixel_in; sof forces (0,0).
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic [PH_W-1:0]  cur_col_ph;
    logic [PH_W-1:0]  cur_row_ph;
    logic [COL_W-1:0] cur_ocol;
    logic [ROW_W-1:0] cur_orow;

    logic [COL_W-1:0] nxt_col;
    logic [ROW_W-1:0] nxt_row;
    logic [PH_W-1:0]  nxt_col_ph;
    logic [PH_W-1:0]  nxt_row_ph;
    logic [COL_W-1:0] nxt_ocol;
    logic [ROW_W-1:0] nxt_orow;

    logic col_hit;
    logic row_hit;
    logic emit;
    logic last_win;

    // K-1 line memories: index 0 holds the most recent complete row,
    // index K-2 the oldest. Contents are never cleared; gating on the
    // position counters keeps stale data out of emitted windows.
    logic [PW-1:0] line_mem [K-1][WIDTH];
    logic [PW-1:0] mem_rd   [K-1];

    logic [PW-1:0] win_q [K][K];
    logic [PW-1:0] win_d [K][K];
    logic [K*K*PW-1:0] win_flat;

    // Resolve the effective position of the incoming pixel (sof restarts).
    always_comb begin
        cur_col    = col_cnt;
        cur_row    = row_cnt;
        cur_col_ph = col_ph;
        cur_row_ph = row_ph;
        cur_ocol   = ocol_cnt;
        cur_orow   = orow_cnt;
        if (sof) begin
            cur_col    = '0;
            cur_row    = '0;
            cur_col_ph = '0;
            cur_row_ph = '0;
            cur_ocol   = '0;
            cur_orow   = '0;
        end
    end

    // Window gating: full KxK support available and aligned to the stride.
    always_comb begin
        col_hit  = (cur_col >= COL_FIRST_HIT) && (cur_col_ph == '0);
        row_hit  = (cur_row >= ROW_FIRST_HIT) && (cur_row_ph == '0);
        emit     = valid_in && col_hit && row_hit;
        last_win = (cur_orow == OROW_LAST) && (cur_ocol == OCOL_LAST);
    end

    // Advance position, phase and window-index counters past the current pixel.
    always_comb begin
        nxt_col    = cur_col;
        nxt_row    = cur_row;
        nxt_col_ph = cur_col_ph;
        nxt_row_ph = cur_row_ph;
        nxt_ocol   = cur_ocol;
        nxt_orow   = cur_orow;
        if (cur_col == COL_LAST) begin
            nxt_col    = '0;
            nxt_col_ph = '0;
            nxt_ocol   = '0;
            if (cur_row == ROW_LAST) begin
                nxt_row    = '0;
                nxt_row_ph = '0;
                nxt_orow   = '0;
            end else begin
                nxt_row = cur_row + 1'b1;
                // Row phase only starts counting once the first window row is reached.
                if (cur_row >= ROW_FIRST_HIT) begin
                    if (cur_row_ph == PH_LAST) begin
                        nxt_row_ph = '0;
                        nxt_orow   = cur_orow + 1'b1;
                    end else begin
                        nxt_row_ph = cur_row_ph + 1'b1;
                    end
                end
            end
        end else begin
            nxt_col = cur_col + 1'b1;
            if (cur_col >= COL_FIRST_HIT) begin
                if (cur_col_ph == PH_LAST) begin
                    nxt_col_ph = '0;
                    nxt_ocol   = cur_ocol + 1'b1;
                end else begin
                    nxt_col_ph = cur_col_ph + 1'b1;
                end
            end
        end
    end

    // Position counter registers, stepped only by accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            col_ph   <= '0;
            row_ph   <= '0;
            ocol_cnt <= '0;
            orow_cnt <= '0;
        end else if (valid_in) begin
            col_cnt  <= nxt_col;
            row_cnt  <= nxt_row;
            col_ph   <= nxt_col_ph;
            row_ph   <= nxt_row_ph;
            ocol_cnt <= nxt_ocol;
            orow_cnt <= nxt_orow;
        end
    end

    // Read all line memories at the current column (read-before-write).
    always_comb begin
        for (int j = 0; j < K - 1; j++) begin
            mem_rd[j] = line_mem[j][cur_col];
        end
    end

    // Push the column down the memory chain: new pixel into the newest row,
    // each memory's old entry into the next-older memory.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            line_mem[0][cur_col] <= pixel_in;
            for (int j = 1; j < K - 1; j++) begin
                line_mem[j][cur_col] <= mem_rd[j-1];
            end
        end
    end

    // Next window: shift one column left, new right column is
    // {oldest memory ... newest memory, pixel_in} from top to bottom.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            win_d[r][K-1] = mem_rd[K-2-r];
        end
        win_d[K-1][K-1] = pixel_in;
    end

    // Pack the next window with the top-left element in the MSB slice.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[(K*K-1-(r*K+c))*PW +: PW] = win_d[r][c];
            end
        end
    end

    // Window shift register, advanced on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (valid_in) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= win_d[r][c];
                end
            end
        end
    end

    // Output stage: pulse valid_out per window, hold data between windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out     <= 1'b0;
            frame_done    <= 1'b0;
            pixel_windows <= '0;
            win_row       <= '0;
            win_col       <= '0;
        end else begin
            valid_out  <= emit;
            frame_done <= emit && last_win;
            if (emit) begin
                pixel_windows <= win_flat;
                win_row       <= cur_orow;
                win_col       <= cur_ocol;
            end
        end
    end

endmodule
